// File: rtl/iccm_sram_resp.sv
// ICCM SRAM responder: synchronous word array behind a RD_LATENCY-deep read pipeline.
// Define ICCM_PARITY_EN to store and check one even-parity bit per word.
module iccm_sram_resp #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_WORDS  = 2048,
  parameter int RD_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  mem_rd,
  input  logic [ADDR_WIDTH-1:0] mem_rd_addr,
  output logic [DATA_WIDTH-1:0] mem_rd_data,
  output logic                  mem_rd_valid,
  input  logic                  mem_wr,
  input  logic [ADDR_WIDTH-1:0] mem_wr_addr,
  input  logic [DATA_WIDTH-1:0] mem_wr_data,
  output logic                  mem_rd_err,
  input  logic                  err_inj
);

  localparam int IDX_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
  localparam int AW1    = ADDR_WIDTH + 1;
  localparam int STAGES = (RD_LATENCY < 1) ? 1 : RD_LATENCY;
  localparam logic [ADDR_WIDTH:0] DEPTH = AW1'(NUM_WORDS);

  generate
    if (RD_LATENCY < 1 || RD_LATENCY > 4) begin : g_bad_latency
      $error("iccm_sram_resp: RD_LATENCY=%0d is outside 1..4", RD_LATENCY);
    end
    if (longint'(NUM_WORDS) > (longint'(1) << ADDR_WIDTH)) begin : g_bad_depth
      $error("iccm_sram_resp: NUM_WORDS=%0d exceeds 2**ADDR_WIDTH", NUM_WORDS);
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem [NUM_WORDS];

  logic             rd_in_range;
  logic             wr_in_range;
  logic             wr_hit;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic             rd_par_bad;
  logic             rd_err_now;

  assign rd_in_range = {1'b0, mem_rd_addr} < DEPTH;
  assign wr_in_range = {1'b0, mem_wr_addr} < DEPTH;
  assign wr_hit      = mem_wr && wr_in_range;
  assign rd_idx      = IDX_W'(mem_rd_addr);
  assign wr_idx      = IDX_W'(mem_wr_addr);
  assign rd_word     = mem[rd_idx];

  // Out-of-range writes are dropped; the array itself is never reset.
  always_ff @(posedge clk) begin
    if (wr_hit) begin
      mem[wr_idx] <= mem_wr_data;
    end
  end

`ifdef ICCM_PARITY_EN
  logic par_mem [NUM_WORDS];

  always_ff @(posedge clk) begin
    if (wr_hit) begin
      par_mem[wr_idx] <= (^mem_wr_data) ^ err_inj;
    end
  end

  assign rd_par_bad = (^rd_word) ^ par_mem[rd_idx];
`else
  logic unused_err_inj;

  assign unused_err_inj = err_inj;
  assign rd_par_bad     = 1'b0;
`endif

  assign rd_err_now = rd_in_range ? rd_par_bad : 1'b1;

  logic [STAGES-1:0]     pipe_valid;
  logic [STAGES-1:0]     pipe_err;
  logic [DATA_WIDTH-1:0] pipe_data [STAGES];

  // Stage 0 samples the array before this edge's write lands (read-before-write);
  // later stages only advance on a valid entry so the output holds between results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pipe_valid <= '0;
      pipe_err   <= '0;
      for (int i = 0; i < STAGES; i++) begin
        pipe_data[i] <= '0;
      end
    end else begin
      pipe_valid[0] <= mem_rd;
      if (mem_rd) begin
        pipe_data[0] <= rd_in_range ? rd_word : '0;
        pipe_err[0]  <= rd_err_now;
      end
      for (int i = 1; i < STAGES; i++) begin
        pipe_valid[i] <= pipe_valid[i-1];
        if (pipe_valid[i-1]) begin
          pipe_data[i] <= pipe_data[i-1];
          pipe_err[i]  <= pipe_err[i-1];
        end
      end
    end
  end

  assign mem_rd_valid = pipe_valid[STAGES-1];
  assign mem_rd_data  = pipe_data[STAGES-1];
  assign mem_rd_err   = pipe_err[STAGES-1] & pipe_valid[STAGES-1];

endmodule

// File: doc/iccm_sram_resp.md
Name: iccm_sram_resp

Overview:
- Memory-side responder for the ICCM controller's mem_rd/mem_wr interface: a synchronous single-port-read, single-port-write instruction memory array.
- Accepts one read and one write per cycle and returns read data after a fixed, parameterised pipeline latency.
- Sits below ccm_controller in the fetch path.
- Serves as the synthesizable ICCM model for both fetch and BIST traffic.

Parameters:
- ADDR_WIDTH, 11, word address width.
- DATA_WIDTH, 32, word width.
- NUM_WORDS, 2048, implemented depth; must satisfy NUM_WORDS <= 2**ADDR_WIDTH.
- RD_LATENCY, 1, cycles from mem_rd sample to mem_rd_valid; legal range 1..4.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- mem_rd  in  1  read request, sampled every cycle.
- mem_rd_addr  in  ADDR_WIDTH  read word address.
- mem_rd_data  out  DATA_WIDTH  read data.
- mem_rd_valid  out  1  one-cycle strobe marking mem_rd_data as valid for a returned read.
- mem_wr  in  1  write request.
- mem_wr_addr  in  ADDR_WIDTH  write word address.
- mem_wr_data  in  DATA_WIDTH  write data.
- mem_rd_err  out  1  read error flag, qualified by mem_rd_valid.
- err_inj  in  1  parity error injection (see Optional Feature).

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.
- Reset values: mem_rd_data = 0, mem_rd_valid = 0, mem_rd_err = 0.
  - All read pipeline stages are cleared: valid bits 0, data 0.
  - Array contents are not reset and are retained across reset.
- Read pipeline:
  - A read with mem_rd=1 sampled at edge N produces mem_rd_valid=1 after edge N+RD_LATENCY.
  - mem_rd_data at that point holds the word at the sampled address.
  - Stage 1 performs the array read; stages 2..RD_LATENCY are pure register delay.
  - Back-to-back reads are fully pipelined: one result per cycle, in order, with no stalls.
- Data hold: mem_rd_data holds its last returned value while mem_rd_valid=0. It only changes when a valid result emerges.
- Writes:
  - A write with mem_wr=1 at edge N updates the array at edge N.
  - The written data is visible to any read sampled at edge N+1 or later.
- Simultaneous read and write to the same address at the same edge: read-before-write. The read returns the old contents; the new data lands in the array.
- Out-of-range addresses (address >= NUM_WORDS):
  - A write is dropped and the array is unchanged.
  - A read returns 0, still raises mem_rd_valid, and sets mem_rd_err=1 on that valid cycle. This applies with or without the macro.
- Reset mid-operation:
  - Asserting rst discards in-flight reads immediately; no valid is produced for them.
  - A write at the same edge as rst assertion is not guaranteed to commit.
  - The first read after rst deasserts behaves normally.
- Uninitialised words read back as X in simulation. The bench must write a word before reading it, except in the reset-retention check.
- Parameter errors: RD_LATENCY outside 1..4, or NUM_WORDS > 2**ADDR_WIDTH, is a configuration error. Flag it with an elaboration-time $error in a generate check.

Optional Feature:
- Macro: ICCM_PARITY_EN.
- With the macro defined:
  - Each word stores one additional even-parity bit, computed over mem_wr_data on write.
  - If err_inj=1 during a write, the stored parity bit is inverted.
  - On read, stored parity is recomputed and compared. A mismatch sets mem_rd_err=1 in the same cycle as mem_rd_valid.
  - mem_rd_data is still returned unmodified; there is no correction.
- Without the macro:
  - No parity storage exists and err_inj is ignored.
  - mem_rd_err asserts only for out-of-range reads.

Test Plan:
- Basic read, RD_LATENCY=1: write 0xDEADBEEF to address 0x010, then read 0x010 next cycle -> mem_rd_valid=1 exactly 1 cycle after the read; data=0xDEADBEEF; mem_rd_err=0.
- Streaming, RD_LATENCY=3: fill addresses 0..7 with value = addr*0x11111111, then issue 8 consecutive reads -> valid high for 8 consecutive cycles starting 3 cycles after the first read; data in order 0x00000000..0x77777777.
- Collision: address 0x020 holds 0x1; in the same cycle read 0x020 and write 0x2 -> returned data=0x1; a read of 0x020 the following cycle returns 0x2.
- Out of range, NUM_WORDS=1024, ADDR_WIDTH=11:
  - Write 0xAAAA5555 to 0x400 -> write dropped.
  - Read 0x400 -> data=0, valid=1, mem_rd_err=1.
  - Read 0x000 -> data unchanged from its prior contents.
- Reset mid-stream, RD_LATENCY=2: issue reads of 0x001 and 0x002, and assert rst one cycle after the first read -> no valid pulses appear; outputs=0.
  - After rst deasserts, reading 0x001 returns its pre-reset contents, confirming retention.
- Parity, with ICCM_PARITY_EN: write 0x0F0F0F0F to 0x030 with err_inj=1, and 0x12345678 to 0x031 with err_inj=0, then read both -> 0x030 returns data=0x0F0F0F0F with mem_rd_err=1; 0x031 returns mem_rd_err=0.
